dual_port_blockram: RTL and testbench
=====================================

# dual_port_blockram

Parametrised true dual-port block RAM, the successor to the single-port blockram in the basic-storage library. Two independent read/write ports (A, B) share one array, each with per-byte write mask, configurable registered read latency and a per-port read-valid strobe. A built-in clear engine zeroes the array after reset when enabled. Used by cache tag/data arrays that need a concurrent fill port and lookup port.

## Interface
- SINGLE_ENTRY_SIZE_IN_BITS, 64, entry width; multiple of `BYTE_LEN_IN_BITS`
- NUM_SET, 64, number of entries
- SET_PTR_WIDTH_IN_BITS, $clog2(NUM_SET), address width
- WRITE_MASK_LEN, SINGLE_ENTRY_SIZE_IN_BITS / `BYTE_LEN_IN_BITS`, byte-enable width
- READ_LATENCY, 1, cycles request-to-data; legal 1..4
- WRITE_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new merged data)
- INIT_ON_RESET, 1, 1 = clear array to zero after reset

Ports (x = a, b):
- clk_in  input  1  clock
- reset_in  input  1  synchronous active-high reset
- access_en_x_in  input  1  port request valid
- write_en_x_in  input  WRITE_MASK_LEN  byte write enables; 0 = read
- access_set_addr_x_in  input  SET_PTR_WIDTH_IN_BITS  entry index
- write_entry_x_in  input  SINGLE_ENTRY_SIZE_IN_BITS  write data
- read_entry_x_out  output  SINGLE_ENTRY_SIZE_IN_BITS  read data
- read_valid_x_out  output  1  read_entry_x_out valid this cycle
- init_done_out  output  1  array ready for access

## Operation
- Every request (access_en high, init_done high) reads the addressed entry; bytes with write_en set are written with write_entry data, others kept.
- Requests with access_en low, or while init_done low, are ignored: no write, no read_valid.
- Read data: WRITE_MODE 0 returns pre-write entry; WRITE_MODE 1 returns post-merge entry. Pure reads (mask 0) identical in both modes.
- Cross-port same-address same-cycle: reads on one port always see pre-cycle contents of bytes written by the other port. Both ports writing the same byte: port A wins.
- read_entry_x_out holds last valid data while read_valid_x_out low.
- Clear FSM: CLEAR -> READY. Reset enters CLEAR if INIT_ON_RESET=1 else READY. CLEAR writes zero to set counter 0..NUM_SET-1, one entry per cycle, then READY. init_done_out = (state == READY).
- INIT_ON_RESET=0: contents undefined after power-up, retained across reset.

## Timing
- Request presented in cycle c (sampled at rising edge ending c); read_valid/data visible in cycle c+READ_LATENCY. Back-to-back requests every cycle, full throughput, per-port in order.
- Write visible to any read issued in a later cycle on either port.
- Reset values: read_entry_x_out = 0, read_valid_x_out = 0, init_done_out = 0 (INIT_ON_RESET=1) or 1 on the cycle after reset deasserts (INIT_ON_RESET=0), clear counter = 0.
- Clear takes exactly NUM_SET cycles after reset deasserts; init_done rises in cycle NUM_SET+1.
- Reset mid-operation: all in-flight reads discarded (no valid emitted), clear restarts from set 0; mid-clear reset restarts clear.
- Address wrap: none; counter stops at NUM_SET-1.

## Structure
- Shared package: WRITE_MODE constants (READ_FIRST=0, WRITE_FIRST=1), clear FSM state encoding; `BYTE_LEN_IN_BITS` stays in parameters.h.
- One sub-module: blockram_read_pipe — READ_LATENCY-1 stage data+valid register chain with synchronous reset, instantiated per port.

## Test plan
- Reset with INIT_ON_RESET=1: init_done low 64 cycles, then high; read set 63 -> 64'h0, valid exactly in cycle c+READ_LATENCY.
- Port A full-mask write 64'hFFFFFFFF_00000000 to set 63, port B read next cycle -> same value; no write when mask 0.
- Set 62 = 0; write 64'hFFFF...FF mask 8'b11001100 -> readback 64'hFFFF0000_FFFF0000.
- Same-cycle A write 64'h1 / B read set 5 (holding 64'h7) -> B returns 64'h7; WRITE_MODE 1 same-port write 64'h1 returns 64'h1, WRITE_MODE 0 returns 64'h7.
- Both ports write set 9 full mask (A 64'hAA.., B 64'h55..) -> readback 64'hAAAA...; READ_LATENCY=3 streaming 64 reads -> 64 in-order valids, no gaps.
- Assert reset with 2 reads in flight and mid-clear -> no valid emitted, clear restarts, init_done after 64 cycles.

Source files
------------

// File: rtl/dual_port_blockram_pkg.sv
// Shared definitions for dual_port_blockram: same-port write-mode constants and clear FSM states.
`ifndef BYTE_LEN_IN_BITS
`define BYTE_LEN_IN_BITS 8
`endif

package dual_port_blockram_pkg;

  localparam int unsigned READ_FIRST  = 0;
  localparam int unsigned WRITE_FIRST = 1;

  typedef enum logic {
    StClear = 1'b0,
    StReady = 1'b1
  } clear_state_e;

endpackage

// File: rtl/dual_port_blockram_read_pipe.sv
// Extra read-latency stages: a data+valid register chain; data holds while valid is low.
module blockram_read_pipe #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             dst_valid,
  output logic [WIDTH-1:0] dst_data
);

  if (STAGES == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = clk ^ reset;
    assign dst_valid   = src_valid;
    assign dst_data    = src_data;
  end else begin : g_stages
    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  data_q [STAGES];

    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= '0;
        for (int i = 0; i < int'(STAGES); i++) data_q[i] <= '0;
      end else begin
        valid_q[0] <= src_valid;
        if (src_valid) data_q[0] <= src_data;
        for (int i = 1; i < int'(STAGES); i++) begin
          valid_q[i] <= valid_q[i-1];
          if (valid_q[i-1]) data_q[i] <= data_q[i-1];
        end
      end
    end

    assign dst_valid = valid_q[STAGES-1];
    assign dst_data  = data_q[STAGES-1];
  end

endmodule

// File: rtl/dual_port_blockram.sv
// True dual-port RAM with per-byte write masks, registered read latency and a post-reset clearer.
module dual_port_blockram
  import dual_port_blockram_pkg::*;
#(
  parameter int unsigned SINGLE_ENTRY_SIZE_IN_BITS = 64,
  parameter int unsigned NUM_SET                   = 64,
  parameter int unsigned SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET),
  parameter int unsigned WRITE_MASK_LEN            = SINGLE_ENTRY_SIZE_IN_BITS / `BYTE_LEN_IN_BITS,
  parameter int unsigned READ_LATENCY              = 1,
  parameter int unsigned WRITE_MODE                = READ_FIRST,
  parameter bit          INIT_ON_RESET             = 1'b1
) (
  input  logic                                 clk_in,
  input  logic                                 reset_in,
  input  logic                                 access_en_a_in,
  input  logic [WRITE_MASK_LEN-1:0]            write_en_a_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     access_set_addr_a_in,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] write_entry_a_in,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] read_entry_a_out,
  output logic                                 read_valid_a_out,
  input  logic                                 access_en_b_in,
  input  logic [WRITE_MASK_LEN-1:0]            write_en_b_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     access_set_addr_b_in,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] write_entry_b_in,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] read_entry_b_out,
  output logic                                 read_valid_b_out,
  output logic                                 init_done_out
);

  localparam int unsigned BL = `BYTE_LEN_IN_BITS;
  localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] LAST_SET = SET_PTR_WIDTH_IN_BITS'(NUM_SET - 1);

  typedef logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] entry_t;

  function automatic entry_t merge_bytes(entry_t old_entry, entry_t new_entry,
                                         logic [WRITE_MASK_LEN-1:0] mask);
    entry_t res;
    res = old_entry;
    for (int i = 0; i < int'(WRITE_MASK_LEN); i++) begin
      if (mask[i]) res[i*BL +: BL] = new_entry[i*BL +: BL];
    end
    return res;
  endfunction

  entry_t mem [NUM_SET];

  clear_state_e                     state_q, state_d;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] clr_cnt_q, clr_cnt_d;
  logic                             clearing, ready;
  logic                             req_a, req_b;
  entry_t                           rd_data_a, rd_data_b;
  logic                             stage_valid_a_q, stage_valid_b_q;
  entry_t                           stage_data_a_q, stage_data_b_q;

  // Clear FSM: state register, next-state logic, outputs.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q   <= INIT_ON_RESET ? StClear : StReady;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StClear: begin
        if (clr_cnt_q == LAST_SET) state_d = StReady;
        else                       clr_cnt_d = clr_cnt_q + 1'b1;
      end
      StReady: ;
      default: state_d = StClear;
    endcase
  end

  always_comb begin
    ready    = (state_q == StReady);
    clearing = (state_q == StClear) && !reset_in;
  end

  assign init_done_out = ready;
  assign req_a = access_en_a_in && ready && !reset_in;
  assign req_b = access_en_b_in && ready && !reset_in;

  // Port A is applied last so it wins any byte both ports write.
  always_ff @(posedge clk_in) begin
    if (clearing) begin
      mem[clr_cnt_q] <= '0;
    end else begin
      for (int i = 0; i < int'(WRITE_MASK_LEN); i++) begin
        if (req_b && write_en_b_in[i])
          mem[access_set_addr_b_in][i*BL +: BL] <= write_entry_b_in[i*BL +: BL];
        if (req_a && write_en_a_in[i])
          mem[access_set_addr_a_in][i*BL +: BL] <= write_entry_a_in[i*BL +: BL];
      end
    end
  end

  // Write-first merges only the port's own write; the other port's write is never forwarded.
  always_comb begin
    rd_data_a = mem[access_set_addr_a_in];
    rd_data_b = mem[access_set_addr_b_in];
    if (WRITE_MODE == WRITE_FIRST) begin
      rd_data_a = merge_bytes(mem[access_set_addr_a_in], write_entry_a_in, write_en_a_in);
      rd_data_b = merge_bytes(mem[access_set_addr_b_in], write_entry_b_in, write_en_b_in);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      stage_valid_a_q <= 1'b0;
      stage_valid_b_q <= 1'b0;
      stage_data_a_q  <= '0;
      stage_data_b_q  <= '0;
    end else begin
      stage_valid_a_q <= req_a;
      stage_valid_b_q <= req_b;
      if (req_a) stage_data_a_q <= rd_data_a;
      if (req_b) stage_data_b_q <= rd_data_b;
    end
  end

  blockram_read_pipe #(
    .WIDTH  (SINGLE_ENTRY_SIZE_IN_BITS),
    .STAGES (READ_LATENCY - 1)
  ) u_pipe_a (
    .clk       (clk_in),
    .reset     (reset_in),
    .src_valid (stage_valid_a_q),
    .src_data  (stage_data_a_q),
    .dst_valid (read_valid_a_out),
    .dst_data  (read_entry_a_out)
  );

  blockram_read_pipe #(
    .WIDTH  (SINGLE_ENTRY_SIZE_IN_BITS),
    .STAGES (READ_LATENCY - 1)
  ) u_pipe_b (
    .clk       (clk_in),
    .reset     (reset_in),
    .src_valid (stage_valid_b_q),
    .src_data  (stage_data_b_q),
    .dst_valid (read_valid_b_out),
    .dst_data  (read_entry_b_out)
  );

endmodule

// File: tb/tb_dual_port_blockram.sv
// Bench for dual_port_blockram: dut0 is read-first/latency 1, dut1 is write-first/latency 3.
module tb_dual_port_blockram;

  logic        clk = 1'b0;
  logic        reset;
  logic        en_a, en_b;
  logic [7:0]  we_a, we_b;
  logic [5:0]  addr_a, addr_b;
  logic [63:0] wd_a, wd_b;
  logic [63:0] rd_a0, rd_b0, rd_a1, rd_b1;
  logic        rv_a0, rv_b0, rv_a1, rv_b1, done0, done1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dual_port_blockram #(
    .READ_LATENCY (1),
    .WRITE_MODE   (0)
  ) dut0 (
    .clk_in               (clk),
    .reset_in             (reset),
    .access_en_a_in       (en_a),
    .write_en_a_in        (we_a),
    .access_set_addr_a_in (addr_a),
    .write_entry_a_in     (wd_a),
    .read_entry_a_out     (rd_a0),
    .read_valid_a_out     (rv_a0),
    .access_en_b_in       (en_b),
    .write_en_b_in        (we_b),
    .access_set_addr_b_in (addr_b),
    .write_entry_b_in     (wd_b),
    .read_entry_b_out     (rd_b0),
    .read_valid_b_out     (rv_b0),
    .init_done_out        (done0)
  );

  dual_port_blockram #(
    .READ_LATENCY (3),
    .WRITE_MODE   (1)
  ) dut1 (
    .clk_in               (clk),
    .reset_in             (reset),
    .access_en_a_in       (en_a),
    .write_en_a_in        (we_a),
    .access_set_addr_a_in (addr_a),
    .write_entry_a_in     (wd_a),
    .read_entry_a_out     (rd_a1),
    .read_valid_a_out     (rv_a1),
    .access_en_b_in       (en_b),
    .write_en_b_in        (we_b),
    .access_set_addr_b_in (addr_b),
    .write_entry_b_in     (wd_b),
    .read_entry_b_out     (rd_b1),
    .read_valid_b_out     (rv_b1),
    .init_done_out        (done1)
  );

  // a0/b0: read-first expected data, a1/b1: write-first expected data (held values when invalid).
  typedef struct {
    logic ea; logic [7:0] wa; logic [5:0] aa; logic [63:0] da;
    logic eb; logic [7:0] wb; logic [5:0] ab; logic [63:0] db;
    logic va; logic [63:0] a0; logic [63:0] a1;
    logic vb; logic [63:0] b0; logic [63:0] b1;
  } vec_t;

  localparam logic [63:0] HI   = 64'hFFFF_FFFF_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] PAT  = 64'hFFFF_0000_FFFF_0000;
  localparam logic [63:0] AA   = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] H55  = 64'h5555_5555_5555_5555;
  localparam logic [63:0] E11  = 64'h1111_1111_1111_1111;
  localparam logic [63:0] E22  = 64'h2222_2222_2222_2222;
  localparam logic [63:0] LO11 = 64'h0000_0000_1111_1111;
  localparam logic [63:0] MIX  = 64'h2222_2222_1111_1111;

  vec_t vecs[17];

  function automatic logic [63:0] pat(int i);
    return {16'hDEAD, 16'(i), 16'(i * 3), 16'hBEEF};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic idle();
    en_a = 1'b0; we_a = '0; addr_a = '0; wd_a = '0;
    en_b = 1'b0; we_b = '0; addr_b = '0; wd_b = '0;
  endtask

  task automatic drive(input vec_t v);
    en_a = v.ea; we_a = v.wa; addr_a = v.aa; wd_a = v.da;
    en_b = v.eb; we_b = v.wb; addr_b = v.ab; wd_b = v.db;
  endtask

  // One request cycle; dut0 checked at c+1, dut1 checked silent at c+1 and answering at c+3.
  task automatic apply(input vec_t v, input string tag);
    @(posedge clk); #1;
    drive(v);
    @(posedge clk); #1;
    idle();
    chk({tag, " d0 valid_a"}, 64'(rv_a0), 64'(v.va));
    chk({tag, " d0 valid_b"}, 64'(rv_b0), 64'(v.vb));
    chk({tag, " d0 data_a"}, rd_a0, v.a0);
    chk({tag, " d0 data_b"}, rd_b0, v.b0);
    chk({tag, " d1 early valid_a"}, 64'(rv_a1), 64'(0));
    chk({tag, " d1 early valid_b"}, 64'(rv_b1), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    chk({tag, " d1 valid_a"}, 64'(rv_a1), 64'(v.va));
    chk({tag, " d1 valid_b"}, 64'(rv_b1), 64'(v.vb));
    chk({tag, " d1 data_a"}, rd_a1, v.a1);
    chk({tag, " d1 data_b"}, rd_b1, v.b1);
  endtask

  // Called at #1 after the last reset-high edge; clear must take exactly 64 cycles.
  task automatic wait_init(input string tag);
    int n;
    int spur;
    n = 0;
    spur = 0;
    while (!(done0 && done1) && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (rv_a0 || rv_b0 || rv_a1 || rv_b1) spur++;
    end
    chk({tag, " clear cycles"}, 64'(n), 64'd64);
    chk({tag, " d0 init_done"}, 64'(done0), 64'd1);
    chk({tag, " d1 init_done"}, 64'(done1), 64'd1);
    chk({tag, " spurious valids"}, 64'(spur), 64'd0);
  endtask

  initial begin
    vecs[0]  = '{1, 8'h00, 6'd63, 64'h0,  0, 8'h00, 6'd0,  64'h0, 1, 64'h0, 64'h0, 0, 64'h0, 64'h0};
    vecs[1]  = '{1, 8'hFF, 6'd63, HI,     0, 8'h00, 6'd0,  64'h0, 1, 64'h0, HI,    0, 64'h0, 64'h0};
    vecs[2]  = '{0, 8'h00, 6'd0,  64'h0,  1, 8'h00, 6'd63, 64'h0, 0, 64'h0, HI,    1, HI,    HI};
    vecs[3]  = '{1, 8'h00, 6'd63, 64'h1234, 0, 8'h00, 6'd0, 64'h0, 1, HI,   HI,    0, HI,    HI};
    vecs[4]  = '{0, 8'h00, 6'd0,  64'h0,  1, 8'h00, 6'd63, 64'h0, 0, HI,    HI,    1, HI,    HI};
    vecs[5]  = '{1, 8'hFF, 6'd62, 64'h0,  0, 8'h00, 6'd0,  64'h0, 1, 64'h0, 64'h0, 0, HI,    HI};
    vecs[6]  = '{1, 8'hCC, 6'd62, ONES,   0, 8'h00, 6'd0,  64'h0, 1, 64'h0, PAT,   0, HI,    HI};
    vecs[7]  = '{0, 8'h00, 6'd0,  64'h0,  1, 8'h00, 6'd62, 64'h0, 0, 64'h0, PAT,   1, PAT,   PAT};
    vecs[8]  = '{1, 8'hFF, 6'd5,  64'h7,  0, 8'h00, 6'd0,  64'h0, 1, 64'h0, 64'h7, 0, PAT,   PAT};
    vecs[9]  = '{1, 8'hFF, 6'd5,  64'h1,  1, 8'h00, 6'd5,  64'h0, 1, 64'h7, 64'h1, 1, 64'h7, 64'h7};
    vecs[10] = '{0, 8'h00, 6'd0,  64'h0,  1, 8'h00, 6'd5,  64'h0, 0, 64'h7, 64'h1, 1, 64'h1, 64'h1};
    vecs[11] = '{1, 8'hFF, 6'd9,  AA,     1, 8'hFF, 6'd9,  H55,   1, 64'h0, AA,    1, 64'h0, H55};
    vecs[12] = '{1, 8'h00, 6'd9,  64'h0,  0, 8'h00, 6'd0,  64'h0, 1, AA,    AA,    0, 64'h0, H55};
    vecs[13] = '{0, 8'hFF, 6'd9,  64'h1234, 1, 8'h00, 6'd9, 64'h0, 0, AA,   AA,    1, AA,    AA};
    vecs[14] = '{1, 8'h00, 6'd9,  64'h0,  0, 8'h00, 6'd0,  64'h0, 1, AA,    AA,    0, AA,    AA};
    vecs[15] = '{1, 8'h0F, 6'd10, E11,    1, 8'hFF, 6'd10, E22,   1, 64'h0, LO11,  1, 64'h0, E22};
    vecs[16] = '{0, 8'h00, 6'd0,  64'h0,  1, 8'h00, 6'd10, 64'h0, 0, 64'h0, LO11,  1, MIX,   MIX};

    idle();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset d0 init_done", 64'(done0), 64'd0);
    chk("reset d1 init_done", 64'(done1), 64'd0);
    chk("reset d0 valid_a", 64'(rv_a0), 64'd0);
    chk("reset d1 valid_b", 64'(rv_b1), 64'd0);
    chk("reset d0 data_b", rd_b0, 64'h0);
    chk("reset d1 data_a", rd_a1, 64'h0);
    reset = 1'b0;
    wait_init("power-up");

    for (int k = 0; k < 17; k++) apply(vecs[k], $sformatf("vec%0d", k));

    // A fills every set, then B streams reads back-to-back starting right after the last write.
    for (int t = 0; t < 133; t++) begin
      @(posedge clk); #1;
      if (t - 1 >= 64 && t - 1 <= 127) begin
        chk($sformatf("stream d0 valid t%0d", t), 64'(rv_b0), 64'd1);
        chk($sformatf("stream d0 data t%0d", t), rd_b0, pat(63 - (t - 1 - 64)));
      end else begin
        chk($sformatf("stream d0 idle t%0d", t), 64'(rv_b0), 64'd0);
      end
      if (t - 3 >= 64 && t - 3 <= 127) begin
        chk($sformatf("stream d1 valid t%0d", t), 64'(rv_b1), 64'd1);
        chk($sformatf("stream d1 data t%0d", t), rd_b1, pat(63 - (t - 3 - 64)));
      end else begin
        chk($sformatf("stream d1 idle t%0d", t), 64'(rv_b1), 64'd0);
      end
      idle();
      if (t < 64) begin
        en_a = 1'b1; we_a = 8'hFF; addr_a = 6'(t); wd_a = pat(t);
      end else if (t < 128) begin
        en_b = 1'b1; addr_b = 6'(63 - (t - 64));
      end
    end

    // Two reads in flight on dut1 when reset hits: neither may emerge.
    @(posedge clk); #1;
    en_b = 1'b1; addr_b = 6'd63;
    @(posedge clk); #1;
    addr_b = 6'd62;
    @(posedge clk); #1;
    chk("inflight d1 valid before reset", 64'(rv_b1), 64'd0);
    chk("inflight d0 second read", rd_b0, pat(62));
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
    chk("inflight d1 valid in reset", 64'(rv_b1), 64'd0);
    chk("inflight d1 data cleared", rd_b1, 64'h0);
    chk("inflight d0 data cleared", rd_b0, 64'h0);
    chk("inflight init_done low", 64'(done0), 64'd0);
    reset = 1'b0;
    wait_init("after inflight reset");

    apply('{0, 8'h00, 6'd0, 64'h0, 1, 8'h00, 6'd63, 64'h0, 0, 64'h0, 64'h0, 1, 64'h0, 64'h0},
          "post-clear read63");

    // Reset partway through a clear restarts it from set 0.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midclear init_done low", 64'(done0), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    wait_init("mid-clear restart");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
